// File: rtl/cpu6_pkg.sv
// Shared CPU6 datapath constants: slot indexing and default data width for the
// read mux and write demux.
package cpu6_pkg;

  localparam int unsigned SEL_W    = 2;
  localparam int unsigned NUM_SLOT = 4;
  localparam int unsigned DATA_W   = 3;

  localparam logic [SEL_W-1:0] SLOT0 = 2'd0;
  localparam logic [SEL_W-1:0] SLOT1 = 2'd1;
  localparam logic [SEL_W-1:0] SLOT2 = 2'd2;
  localparam logic [SEL_W-1:0] SLOT3 = 2'd3;

  // One-hot slot mask for a select index, or all slots on broadcast.
  function automatic logic [NUM_SLOT-1:0] slot_mask(logic [SEL_W-1:0] sel, logic bcast);
    logic [NUM_SLOT-1:0] mask;
    mask = '0;
    if (bcast) begin
      mask = '1;
    end else begin
      unique case (sel)
        SLOT0:   mask = 4'b0001;
        SLOT1:   mask = 4'b0010;
        SLOT2:   mask = 4'b0100;
        SLOT3:   mask = 4'b1000;
        default: mask = '0;
      endcase
    end
    return mask;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One demux destination slot: a data register plus a full/empty valid bit.
module demux_slot
  import cpu6_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // Writes are only issued when free, so a write never clobbers an unread word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (wr) begin
      data_q  <= wdata;
      valid_q <= 1'b1;
    end else if (rd_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign free  = !valid_q | rd_ready;

endmodule

// File: rtl/demux_1_to_4_reg.sv
// Registered 1-to-4 write demux with valid/ready per slot, broadcast, and an
// accepted-transfer counter.
module demux_1_to_4_reg
  import cpu6_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_bcast,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out0_data,
  output logic [WIDTH-1:0]    out1_data,
  output logic [WIDTH-1:0]    out2_data,
  output logic [WIDTH-1:0]    out3_data,
  output logic [NUM_SLOT-1:0] out_valid,
  input  logic [NUM_SLOT-1:0] out_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    xfer_count
);

  logic [NUM_SLOT-1:0] free;
  logic [NUM_SLOT-1:0] wr;
  logic [WIDTH-1:0]    slot_data [NUM_SLOT];
  logic                accept;
  logic [CNT_W-1:0]    xfer_count_q;

  // Broadcast is all-or-nothing: every slot must be free in the same cycle.
  assign in_ready = in_bcast ? &free : free[in_sel];
  assign accept   = in_valid & in_ready;
  assign wr       = accept ? slot_mask(in_sel, in_bcast) : '0;

  for (genvar k = 0; k < NUM_SLOT; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr[k]),
      .wdata    (in_data),
      .rd_ready (out_ready[k]),
      .data     (slot_data[k]),
      .valid    (out_valid[k]),
      .free     (free[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_q <= '0;
    end else if (accept) begin
      xfer_count_q <= xfer_count_q + 1'b1;
    end
  end

  assign out0_data  = slot_data[0];
  assign out1_data  = slot_data[1];
  assign out2_data  = slot_data[2];
  assign out3_data  = slot_data[3];
  assign busy       = |out_valid;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_demux_1_to_4_reg.sv
// Directed self-checking bench for demux_1_to_4_reg.
module tb_demux_1_to_4_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic       in_bcast = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] out0_data, out1_data, out2_data, out3_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic       busy;
  logic [7:0] xfer_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  demux_1_to_4_reg #(
    .WIDTH (3),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_bcast   (in_bcast),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out1_data  (out1_data),
    .out2_data  (out2_data),
    .out3_data  (out3_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; registered outputs are settled afterwards.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_data(input string tag, input logic [2:0] exp);
    check({tag, "_d0"}, 32'(out0_data), 32'(exp));
    check({tag, "_d1"}, 32'(out1_data), 32'(exp));
    check({tag, "_d2"}, 32'(out2_data), 32'(exp));
    check({tag, "_d3"}, 32'(out3_data), 32'(exp));
  endtask

  initial begin
    // 1. Reset
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check_all_data("rst", 3'd0);
    check("rst_count", 32'(xfer_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // 2. Single write to slot 2, held with no consumer
    in_sel = 2'd2; in_data = 3'b101; in_valid = 1'b1;
    #1;
    check("w2_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("w2_valid", 32'(out_valid), 32'b0100);
    check("w2_data", 32'(out2_data), 32'b101);
    check("w2_count", 32'(xfer_count), 32'd1);
    check("w2_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("w2_hold_valid", 32'(out_valid), 32'b0100);
      check("w2_hold_data", 32'(out2_data), 32'b101);
    end
    #1;
    check("w2_full_ready_nv", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 3'b010;
    #1;
    check("w2_full_ready_v", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    check("w2_no_overwrite", 32'(out2_data), 32'b101);
    check("w2_count_hold", 32'(xfer_count), 32'd1);
    in_sel = 2'd0;
    #1;
    check("sel0_ready", 32'(in_ready), 32'd1);

    // 3. Streaming into slot 1 with consumer always ready
    in_sel = 2'd1; out_ready = 4'b0010; in_valid = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      in_data = 3'(w);
      #1;
      check("s1_ready", 32'(in_ready), 32'd1);
      tick();
      check("s1_data", 32'(out1_data), 32'(w));
      check("s1_valid", 32'(out_valid), 32'b0110);
    end
    in_valid = 1'b0;
    tick();
    check("s1_drained", 32'(out_valid), 32'b0100);
    check("s1_data_hold", 32'(out1_data), 32'd4);
    check("s1_count", 32'(xfer_count), 32'd5);
    out_ready = 4'b0000;

    // 4. Broadcast blocked by full slot 3, then released
    in_sel = 2'd3; in_data = 3'b110; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("f3_valid", 32'(out_valid), 32'b1100);
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    check("f3_drain2", 32'(out_valid), 32'b1000);
    in_bcast = 1'b1; in_data = 3'b111; in_valid = 1'b1;
    #1;
    check("bc_blocked_ready", 32'(in_ready), 32'd0);
    tick();
    check("bc_blocked_valid", 32'(out_valid), 32'b1000);
    check("bc_blocked_d3", 32'(out3_data), 32'b110);
    check("bc_blocked_d1", 32'(out1_data), 32'd4);
    check("bc_blocked_count", 32'(xfer_count), 32'd6);
    out_ready = 4'b1000;
    #1;
    check("bc_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
    check("bc_valid", 32'(out_valid), 32'b1111);
    check_all_data("bc", 3'b111);
    check("bc_count", 32'(xfer_count), 32'd7);

    // 5. Reset with words pending
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    check("pre_rst_valid", 32'(out_valid), 32'b1011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check_all_data("mid_rst", 3'd0);
    check("mid_rst_count", 32'(xfer_count), 32'd0);

    // 6. Counter wrap after 256 accepted writes
    in_sel = 2'd0; out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 3'(i);
      tick();
      if (i == 254) check("wrap_255", 32'(xfer_count), 32'd255);
    end
    in_valid = 1'b0;
    check("wrap_count", 32'(xfer_count), 32'd0);
    check("wrap_valid", 32'(out_valid), 32'b0001);
    check("wrap_d0", 32'(out0_data), 32'd7);
    check("wrap_d1", 32'(out1_data), 32'd0);
    tick();
    check("wrap_drained", 32'(out_valid), 32'h0);
    check("wrap_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
